hook_motion: RTL and testbench



---
 rtl/fish_pkg.sv | 42 ++++
 rtl/tick_gen.sv | 43 ++++
 rtl/hook_motion.sv | 170 +++++++++++++++++
 tb/tb_hook_motion.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fish_pkg.sv
// ============================================================================
// fish_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared definitions for the fishing-game motion blocks: the hook
//           FSM state encoding, the screen geometry the overlay renderer uses,
//           and the fixed-point position width.
//
// Contents:
//   hook_state_t  hook FSM states (IDLE=0, DROP=1, WAIT=2, REEL=3)
//   LINE_X        screen column of the fishing line (pixels)
//   ROD_TOP_Y     screen row of the rod tip (pixels)
//   SCALE         sub-pixel scale factor (positions are in 0.1 pixel)
//   POS_W         width of every position value
//   to_pos        helper converting a pixel coordinate to a scaled position
// ============================================================================
package fish_pkg;

    // Hook FSM encoding. The numeric values are visible on the state port,
    // so other blocks (and the renderer) may rely on them.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DROP = 3'd1,
        WAIT = 3'd2,
        REEL = 3'd3
    } hook_state_t;

    // Screen geometry in whole pixels.
    localparam int LINE_X    = 258;
    localparam int ROD_TOP_Y = 72;

    // Positions are carried in tenths of a pixel.
    localparam int SCALE = 10;

    // 14 bits covers 0..16383, i.e. 0..1638.3 pixels.
    localparam int POS_W = 14;

    // Converts a whole-pixel coordinate into the scaled position domain.
    function automatic int to_pos(input int pixels);
        return pixels * SCALE;
    endfunction

endpackage : fish_pkg

// File: rtl/tick_gen.sv
// ============================================================================
// tick_gen
// ----------------------------------------------------------------------------
// Purpose : Free-running divider producing a one-cycle tick every DIV clocks.
//           Meant to be shared by anything that moves on the motion timebase
//           (the hook, fish sprites, ...).
//
// Parameters:
//   DIV   number of clock cycles per tick (>= 1)
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous, active-high reset; counter returns to 0
//   tick  out  high for one cycle while the counter sits at DIV-1
// ============================================================================
module tick_gen #(
    parameter int DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A divider of 1 still needs a one-bit counter to stay legal.
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count;

    // The tick is decoded straight from the counter so it lines up with the
    // last count value of each period; the counter wraps on that same cycle.
    assign tick = (count == CNT_W'(DIV - 1));

    // Counter runs 0..DIV-1 and restarts from 0 after a reset, so the first
    // tick after reset release always lands DIV cycles later.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : tick_gen

// File: rtl/hook_motion.sv
// ============================================================================
// hook_motion
// ----------------------------------------------------------------------------
// Purpose : Hook position generator feeding the line/hook overlay renderer.
//           Runs the cast / drop / wait / reel cycle from the player buttons
//           and the fish collision signal, and emits a one-cycle score pulse
//           when a hook carrying a fish gets back to the rod tip.
//
// Parameters (positions in tenths of a pixel):
//   TICK_DIV           clock cycles per motion tick
//   H_POS              fixed hook x position
//   V_TOP              resting y position (rod tip)
//   V_BOTTOM           deepest y position, must be < 16384
//   DROP_SPEED         y increment per tick while dropping
//   REEL_SPEED         y decrement per tick while reeling empty
//   REEL_SPEED_LOADED  y decrement per tick while reeling a fish
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   btn_cast     in   one-cycle cast pulse (debounced)
//   btn_reel     in   one-cycle reel pulse (debounced)
//   catch_hit    in   level, hook overlaps a fish this cycle
//   h_position   out  hook x, constant H_POS
//   v_position   out  hook y, registered
//   state        out  FSM state in fish_pkg encoding
//   loaded       out  a fish is attached
//   busy         out  state is not IDLE (registered)
//   score_pulse  out  one-cycle pulse on a loaded return
// ============================================================================
module hook_motion
    import fish_pkg::*;
#(
    parameter int TICK_DIV          = 1000000,
    parameter int H_POS             = to_pos(LINE_X),
    parameter int V_TOP             = to_pos(ROD_TOP_Y),
    parameter int V_BOTTOM          = 4700,
    parameter int DROP_SPEED        = 20,
    parameter int REEL_SPEED        = 30,
    parameter int REEL_SPEED_LOADED = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_cast,
    input  logic             btn_reel,
    input  logic             catch_hit,
    output logic [POS_W-1:0] h_position,
    output logic [POS_W-1:0] v_position,
    output logic [2:0]       state,
    output logic             loaded,
    output logic             busy,
    output logic             score_pulse
);

    localparam logic [POS_W-1:0] V_TOP_POS    = POS_W'(V_TOP);
    localparam logic [POS_W-1:0] V_BOTTOM_POS = POS_W'(V_BOTTOM);

    hook_state_t      cur_state;
    logic             tick;

    logic [POS_W:0]        drop_sum;
    logic [POS_W-1:0]      drop_next;
    logic                  drop_at_bottom;
    logic [POS_W-1:0]      reel_speed;
    logic signed [POS_W:0] reel_diff;
    logic [POS_W-1:0]      reel_next;
    logic                  reel_at_top;

    // Motion timebase: all position updates wait for this tick.
    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign h_position = POS_W'(H_POS);
    assign state      = cur_state;

    // Candidate positions for the next tick in each moving state. The drop
    // sum gets one extra bit so it cannot wrap before saturating at the
    // bottom; the reel difference is signed so it can dip below V_TOP and
    // be clamped back instead of wrapping to a huge value.
    always_comb begin
        drop_sum       = {1'b0, v_position} + (POS_W + 1)'(DROP_SPEED);
        drop_at_bottom = (drop_sum >= (POS_W + 1)'(V_BOTTOM));
        drop_next      = drop_at_bottom ? V_BOTTOM_POS : drop_sum[POS_W-1:0];

        reel_speed  = loaded ? POS_W'(REEL_SPEED_LOADED) : POS_W'(REEL_SPEED);
        reel_diff   = $signed({1'b0, v_position}) - $signed({1'b0, reel_speed});
        reel_at_top = (reel_diff <= $signed({1'b0, V_TOP_POS}));
        reel_next   = reel_at_top ? V_TOP_POS : reel_diff[POS_W-1:0];
    end

    // Hook FSM with all outputs registered. Inputs redirect the state on the
    // very next edge; the position only moves on tick cycles. In DROP the
    // fish catch outranks the reel button, which outranks hitting bottom.
    // A return to the top while reeling wins over a simultaneous catch, so
    // an empty hook arriving home never scores.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= IDLE;
            v_position  <= V_TOP_POS;
            loaded      <= 1'b0;
            busy        <= 1'b0;
            score_pulse <= 1'b0;
        end else begin
            score_pulse <= 1'b0;
            unique case (cur_state)
                IDLE: begin
                    v_position <= V_TOP_POS;
                    if (btn_cast) begin
                        cur_state <= DROP;
                        busy      <= 1'b1;
                    end
                end

                DROP: begin
                    if (tick) begin
                        v_position <= drop_next;
                    end
                    if (catch_hit) begin
                        cur_state <= REEL;
                        loaded    <= 1'b1;
                    end else if (btn_reel) begin
                        cur_state <= REEL;
                        loaded    <= 1'b0;
                    end else if (tick && drop_at_bottom) begin
                        cur_state <= WAIT;
                    end
                end

                WAIT: begin
                    if (catch_hit) begin
                        cur_state <= REEL;
                        loaded    <= 1'b1;
                    end else if (btn_reel) begin
                        cur_state <= REEL;
                        loaded    <= 1'b0;
                    end
                end

                REEL: begin
                    if (tick) begin
                        v_position <= reel_next;
                        if (reel_at_top) begin
                            cur_state   <= IDLE;
                            busy        <= 1'b0;
                            score_pulse <= loaded;
                            loaded      <= 1'b0;
                        end else if (catch_hit) begin
                            loaded <= 1'b1;
                        end
                    end else if (catch_hit) begin
                        loaded <= 1'b1;
                    end
                end

                default: begin
                    cur_state  <= IDLE;
                    v_position <= V_TOP_POS;
                    loaded     <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule : hook_motion

// File: tb/tb_hook_motion.sv
// ============================================================================
// tb_hook_motion
// ----------------------------------------------------------------------------
// Purpose : Self-checking bench for hook_motion with a fast motion tick.
//           Directed scenarios cover cast, bottom saturation, loaded and
//           empty returns and reset mid-reel; a random phase follows. Every
//           cycle the DUT outputs are compared against a behavioural model.
// ============================================================================
module tb_hook_motion;

    localparam int TICK_DIV = 4;
    localparam int H_POS    = 2580;
    localparam int V_TOP    = 720;
    localparam int V_BOTTOM = 4700;
    localparam int DROP_SP  = 20;
    localparam int REEL_SP  = 30;
    localparam int REEL_SPL = 10;

    localparam int S_IDLE = 0;
    localparam int S_DROP = 1;
    localparam int S_WAIT = 2;
    localparam int S_REEL = 3;

    logic        clk;
    logic        rst;
    logic        btn_cast;
    logic        btn_reel;
    logic        catch_hit;
    logic [13:0] h_position;
    logic [13:0] v_position;
    logic [2:0]  state;
    logic        loaded;
    logic        busy;
    logic        score_pulse;

    int checkCount = 0;
    int errorCount = 0;

    // Behavioural model state, all plain integers.
    int mState  = S_IDLE;
    int mV      = V_TOP;
    int mLoaded = 0;
    int mScore  = 0;
    int mCycle  = 0;
    int dropTicks = 0;
    int scoreSeen = 0;

    hook_motion #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_cast    (btn_cast),
        .btn_reel    (btn_reel),
        .catch_hit   (catch_hit),
        .h_position  (h_position),
        .v_position  (v_position),
        .state       (state),
        .loaded      (loaded),
        .busy        (busy),
        .score_pulse (score_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Compares every DUT output against the model after an edge.
    task automatic compareAll();
        checkOutput("state", int'(state), mState);
        checkOutput("v_position", int'(v_position), mV);
        checkOutput("h_position", int'(h_position), H_POS);
        checkOutput("loaded", int'(loaded), mLoaded);
        checkOutput("busy", int'(busy), (mState != S_IDLE) ? 1 : 0);
        checkOutput("score_pulse", int'(score_pulse), mScore);
    endtask

    // Drives one cycle of inputs, advances the model by the rules of the
    // hook (a tick every TICK_DIV cycles counted from reset), then checks.
    task automatic applyStimulus(input bit r, input bit c, input bit rl, input bit ch);
        bit tick;
        int nv;
        @(negedge clk);
        rst       = r;
        btn_cast  = c;
        btn_reel  = rl;
        catch_hit = ch;

        tick   = (mCycle % TICK_DIV) == (TICK_DIV - 1);
        mScore = 0;
        if (r) begin
            mState  = S_IDLE;
            mV      = V_TOP;
            mLoaded = 0;
            mCycle  = 0;
        end else begin
            case (mState)
                S_IDLE: begin
                    mV = V_TOP;
                    if (c) begin
                        mState    = S_DROP;
                        dropTicks = 0;
                    end
                end
                S_DROP: begin
                    nv = mV;
                    if (tick) begin
                        nv = (mV + DROP_SP > V_BOTTOM) ? V_BOTTOM : mV + DROP_SP;
                        dropTicks++;
                    end
                    if (ch) begin
                        mState = S_REEL; mLoaded = 1;
                    end else if (rl) begin
                        mState = S_REEL; mLoaded = 0;
                    end else if (tick && nv == V_BOTTOM) begin
                        mState = S_WAIT;
                    end
                    mV = nv;
                end
                S_WAIT: begin
                    if (ch) begin
                        mState = S_REEL; mLoaded = 1;
                    end else if (rl) begin
                        mState = S_REEL; mLoaded = 0;
                    end
                end
                default: begin
                    if (tick) begin
                        nv = mV - (mLoaded ? REEL_SPL : REEL_SP);
                        if (nv <= V_TOP) begin
                            nv      = V_TOP;
                            mState  = S_IDLE;
                            mScore  = mLoaded;
                            mLoaded = 0;
                        end else if (ch) begin
                            mLoaded = 1;
                        end
                        mV = nv;
                    end else if (ch) begin
                        mLoaded = 1;
                    end
                end
            endcase
            mCycle++;
        end
        scoreSeen += mScore;

        @(posedge clk);
        #1;
        compareAll();
    endtask

    // Runs idle cycles until the model reaches the requested state or value,
    // with a cycle budget; an expired budget is reported as a failed check.
    task automatic runUntilV(input string tag, input int target, input int budget);
        int n = 0;
        while (mV != target && n < budget) begin
            applyStimulus(0, 0, 0, 0);
            n++;
        end
        checkOutput(tag, mV, target);
    endtask

    task automatic runUntilState(input string tag, input int target, input int budget);
        int n = 0;
        while (mState != target && n < budget) begin
            applyStimulus(0, 0, 0, 0);
            n++;
        end
        checkOutput(tag, mState, target);
    endtask

    task automatic doReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1, 0, 0, 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        btn_cast  = 1'b0;
        btn_reel  = 1'b0;
        catch_hit = 1'b0;

        // Reset values.
        doReset(2);
        checkOutput("reset_state", int'(state), S_IDLE);
        checkOutput("reset_v", int'(v_position), V_TOP);
        checkOutput("reset_h", int'(h_position), H_POS);
        checkOutput("reset_loaded", int'(loaded), 0);
        checkOutput("reset_busy", int'(busy), 0);

        // Cast and drop: ten ticks take the hook from 720 to 920.
        applyStimulus(0, 1, 0, 0);
        checkOutput("cast_state", int'(state), S_DROP);
        for (int n = 0; n < 100 && dropTicks < 10; n++) begin
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("drop_10_ticks", int'(v_position), 920);

        // Bottom saturation: WAIT is entered on tick 199 at exactly 4700.
        runUntilState("reach_wait", S_WAIT, 2000);
        checkOutput("bottom_ticks", dropTicks, 199);
        checkOutput("bottom_v", int'(v_position), V_BOTTOM);
        for (int i = 0; i < 50 * TICK_DIV; i++) begin
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("wait_hold_v", int'(v_position), V_BOTTOM);
        checkOutput("wait_hold_state", int'(state), S_WAIT);

        // Catch and reel together at 1000, then a loaded return to the top.
        doReset(1);
        applyStimulus(0, 1, 0, 0);
        runUntilV("drop_to_1000", 1000, 200);
        applyStimulus(0, 0, 1, 1);
        checkOutput("catch_reel_state", int'(state), S_REEL);
        checkOutput("catch_reel_loaded", int'(loaded), 1);
        scoreSeen = 0;
        runUntilState("loaded_return", S_IDLE, 500);
        checkOutput("loaded_return_score", int'(score_pulse), 1);
        checkOutput("loaded_return_v", int'(v_position), V_TOP);
        applyStimulus(0, 0, 0, 0);
        checkOutput("score_one_cycle", int'(score_pulse), 0);
        checkOutput("score_count", scoreSeen, 1);

        // Empty reel from 740 clamps to 720, not 710, without scoring.
        applyStimulus(0, 1, 0, 0);
        runUntilV("drop_to_740", 740, 100);
        applyStimulus(0, 0, 1, 0);
        scoreSeen = 0;
        runUntilState("empty_return", S_IDLE, 100);
        checkOutput("clamp_v", int'(v_position), V_TOP);
        checkOutput("clamp_score", scoreSeen, 0);

        // Reset in the middle of reeling at 2000.
        applyStimulus(0, 1, 0, 0);
        runUntilV("drop_to_2000", 2000, 1000);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("midreel_rst_v", int'(v_position), V_TOP);
        checkOutput("midreel_rst_state", int'(state), S_IDLE);
        checkOutput("midreel_rst_loaded", int'(loaded), 0);
        checkOutput("midreel_rst_score", int'(score_pulse), 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("first_tick_not_yet", int'(v_position), V_TOP);
        applyStimulus(0, 0, 0, 0);
        checkOutput("first_tick_after_rst", int'(v_position), V_TOP + DROP_SP);

        // Random phase: sparse button pulses, catch bursts, rare resets.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(0, 599) == 0),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_hook_motion
